// File: rtl/serial_rx_pkg.sv
// Shared definitions for the configurable asynchronous serial receiver.
package serial_rx_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BREAK_WAIT
  } rx_state_t;

  // Elaboration-time sanity check of a receiver parameter set.
  function automatic bit rx_cfg_legal(input int data_bits, input int parity,
                                      input int stop_bits, input int div_bits,
                                      input int idle_bits);
    return (data_bits >= 5) && (data_bits <= 9) &&
           (parity >= PAR_NONE) && (parity <= PAR_EVEN) &&
           ((stop_bits == 1) || (stop_bits == 2)) &&
           (div_bits >= 3) && (idle_bits >= 1);
  endfunction

endpackage

// File: rtl/serial_bit_sampler.sv
// Bit-period timer with full-period majority vote on the synchronised line.
module serial_bit_sampler
  import serial_rx_pkg::*;
#(
  parameter int DIV_BITS = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_load,
  input  logic                i_run,
  input  logic [DIV_BITS-1:0] i_divisor,
  input  logic                i_serial,
  output logic                o_bit_done,
  output logic                o_bit_value
);

  logic [DIV_BITS-1:0] r_shadow;
  logic [DIV_BITS-1:0] r_timer;
  logic [DIV_BITS-1:0] r_ones;
  logic [DIV_BITS-1:0] w_ones_next;
  logic                w_last;

  // The final clock's sample is part of the vote, so it is folded in here.
  assign w_ones_next = r_ones + DIV_BITS'(i_serial);
  assign w_last      = (r_timer == (r_shadow - DIV_BITS'(1)));
  assign o_bit_done  = i_run && w_last;
  assign o_bit_value = (w_ones_next >= (r_shadow >> 1));

  // Load latches the divisor on the start-detect sample (counted as a zero);
  // otherwise time one bit period and accumulate high samples.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_shadow <= '0;
      r_timer  <= '0;
      r_ones   <= '0;
    end else if (i_load) begin
      r_shadow <= i_divisor;
      r_timer  <= DIV_BITS'(1);
      r_ones   <= '0;
    end else if (i_run) begin
      if (w_last) begin
        r_timer <= '0;
        r_ones  <= '0;
      end else begin
        r_timer <= r_timer + DIV_BITS'(1);
        r_ones  <= w_ones_next;
      end
    end
  end

endmodule

// File: rtl/serial_rx_cfg.sv
// Configurable asynchronous serial receiver: data width, parity, stop bits,
// runtime divisor, framing/parity errors, break detect and idle timeout.
module serial_rx_cfg
  import serial_rx_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1,
  parameter int DIV_BITS  = 16,
  parameter int IDLE_BITS = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 serial_in,
  input  logic [DIV_BITS-1:0]  divisor,
  input  logic [IDLE_BITS-1:0] idle_limit,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 break_det,
  output logic                 idle_timeout,
  output logic                 busy
);

  localparam int CNT_W = $clog2(DATA_BITS + 1);

  if (!rx_cfg_legal(DATA_BITS, PARITY, STOP_BITS, DIV_BITS, IDLE_BITS)) begin : g_cfg_check
    $error("serial_rx_cfg: illegal parameter set");
  end

  rx_state_t            r_state;
  logic [1:0]           r_sync;
  logic [CNT_W-1:0]     r_cnt;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] r_data;
  logic [IDLE_BITS-1:0] r_idle_timer;
  logic                 r_par, r_zero, r_perr_pend, r_ferr_pend;
  logic                 r_valid, r_perr, r_ferr, r_brk, r_idle_to, r_busy;

  logic                 w_rx, w_load, w_run, w_bit_done, w_bit_value, w_par_err;
  logic [IDLE_BITS-1:0] w_idle_next;

  assign w_rx   = r_sync[1];
  assign w_load = (r_state == ST_IDLE) && !w_rx;
  assign w_run  = (r_state == ST_START) || (r_state == ST_DATA) ||
                  (r_state == ST_PARITY) || (r_state == ST_STOP);

  assign w_idle_next = (r_idle_timer >= idle_limit) ? r_idle_timer
                                                    : r_idle_timer + IDLE_BITS'(1);

  assign w_par_err = (PARITY == PAR_ODD)  ? ~(r_par ^ w_bit_value) :
                     (PARITY == PAR_EVEN) ?  (r_par ^ w_bit_value) : 1'b0;

  assign data_out     = r_data;
  assign data_valid   = r_valid;
  assign parity_err   = r_perr;
  assign frame_err    = r_ferr;
  assign break_det    = r_brk;
  assign idle_timeout = r_idle_to;
  assign busy         = r_busy;

  // Two-flop synchroniser; resets to the idle-high line level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_sync <= '1;
    else       r_sync <= {r_sync[0], serial_in};
  end

  serial_bit_sampler #(.DIV_BITS(DIV_BITS)) u_sampler (
    .clk         (clk),
    .reset       (reset),
    .i_load      (w_load),
    .i_run       (w_run),
    .i_divisor   (divisor),
    .i_serial    (w_rx),
    .o_bit_done  (w_bit_done),
    .o_bit_value (w_bit_value)
  );

  // Frame FSM with registered strobes, error flags and idle timer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_shift      <= '0;
      r_data       <= '0;
      r_idle_timer <= '0;
      r_par        <= 1'b0;
      r_zero       <= 1'b0;
      r_perr_pend  <= 1'b0;
      r_ferr_pend  <= 1'b0;
      r_valid      <= 1'b0;
      r_perr       <= 1'b0;
      r_ferr       <= 1'b0;
      r_brk        <= 1'b0;
      r_idle_to    <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_brk   <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_idle_timer <= w_idle_next;
          r_idle_to    <= (w_idle_next >= idle_limit);
          if (!w_rx) begin
            r_state <= ST_START;
            r_busy  <= 1'b1;
          end
        end
        ST_START: begin
          if (w_bit_done) begin
            if (w_bit_value) begin
              // False start: idle timer and timeout are left as they were.
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_idle_timer <= '0;
              r_idle_to    <= (idle_limit == '0);
              r_cnt        <= '0;
              r_par        <= 1'b0;
              r_zero       <= 1'b1;
              r_perr_pend  <= 1'b0;
              r_ferr_pend  <= 1'b0;
              r_state      <= ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (w_bit_done) begin
            r_shift <= {w_bit_value, r_shift[DATA_BITS-1:1]};
            r_par   <= r_par ^ w_bit_value;
            r_zero  <= r_zero & ~w_bit_value;
            if (r_cnt == CNT_W'(DATA_BITS - 1)) begin
              r_cnt   <= '0;
              r_state <= (PARITY == PAR_NONE) ? ST_STOP : ST_PARITY;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
        end
        ST_PARITY: begin
          if (w_bit_done) begin
            r_perr_pend <= w_par_err;
            r_zero      <= r_zero & ~w_bit_value;
            r_state     <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (w_bit_done) begin
            if ((r_cnt == '0) && r_zero && !w_bit_value) begin
              // Break is decided on the first stop bit, even with two stop bits.
              r_data       <= '0;
              r_valid      <= 1'b1;
              r_perr       <= 1'b0;
              r_ferr       <= 1'b1;
              r_brk        <= 1'b1;
              r_idle_timer <= '0;
              r_idle_to    <= (idle_limit == '0);
              r_state      <= ST_BREAK_WAIT;
            end else if (r_cnt == CNT_W'(STOP_BITS - 1)) begin
              r_data       <= r_shift;
              r_valid      <= 1'b1;
              r_perr       <= r_perr_pend;
              r_ferr       <= r_ferr_pend | ~w_bit_value;
              r_idle_timer <= '0;
              r_idle_to    <= (idle_limit == '0);
              r_state      <= ST_IDLE;
              r_busy       <= 1'b0;
            end else begin
              r_ferr_pend <= r_ferr_pend | ~w_bit_value;
              r_cnt       <= r_cnt + CNT_W'(1);
            end
          end
        end
        ST_BREAK_WAIT: begin
          if (w_rx) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_rx_cfg.sv
// Self-checking bench: three receiver configurations (8N1, 7E1, 8N2).
module tb_serial_rx_cfg;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  r_line;
  logic [15:0] divisor;
  logic [15:0] idle_limit;
  logic [7:0]  dout0, dout2;
  logic [6:0]  dout1;
  logic [2:0]  valid, perr, ferr, brk, ito, busy;

  int cyc   = 0;
  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic        valid;
    logic [1:0]  inst;
    logic [8:0]  data;
    logic        perr;
    logic        ferr;
    logic        brk;
    logic [31:0] cyc;
  } ev_t;

  ev_t evq[$];
  ev_t m_ev;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_rx_cfg #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .DIV_BITS(16), .IDLE_BITS(16)) u_8n1 (
    .clk(clk), .reset(reset), .serial_in(r_line[0]), .divisor(divisor), .idle_limit(idle_limit),
    .data_out(dout0), .data_valid(valid[0]), .parity_err(perr[0]), .frame_err(ferr[0]),
    .break_det(brk[0]), .idle_timeout(ito[0]), .busy(busy[0]));

  serial_rx_cfg #(.DATA_BITS(7), .PARITY(2), .STOP_BITS(1), .DIV_BITS(16), .IDLE_BITS(16)) u_7e1 (
    .clk(clk), .reset(reset), .serial_in(r_line[1]), .divisor(divisor), .idle_limit(idle_limit),
    .data_out(dout1), .data_valid(valid[1]), .parity_err(perr[1]), .frame_err(ferr[1]),
    .break_det(brk[1]), .idle_timeout(ito[1]), .busy(busy[1]));

  serial_rx_cfg #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(2), .DIV_BITS(16), .IDLE_BITS(16)) u_8n2 (
    .clk(clk), .reset(reset), .serial_in(r_line[2]), .divisor(divisor), .idle_limit(idle_limit),
    .data_out(dout2), .data_valid(valid[2]), .parity_err(perr[2]), .frame_err(ferr[2]),
    .break_det(brk[2]), .idle_timeout(ito[2]), .busy(busy[2]));

  // Record every strobe on the falling edge, away from the active edge.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (valid[i] || brk[i]) begin
        m_ev.valid = valid[i];
        m_ev.inst  = 2'(i);
        m_ev.data  = (i == 0) ? {1'b0, dout0} : (i == 1) ? {2'b0, dout1} : {1'b0, dout2};
        m_ev.perr  = perr[i];
        m_ev.ferr  = ferr[i];
        m_ev.brk   = brk[i];
        m_ev.cyc   = 32'(cyc);
        evq.push_back(m_ev);
      end
    end
  end

  function automatic string fmt(input ev_t e);
    return $sformatf("inst=%0d valid=%b data=%h perr=%b ferr=%b brk=%b cyc=%0d",
                     e.inst, e.valid, e.data, e.perr, e.ferr, e.brk, e.cyc);
  endfunction

  // Reference outcome of one frame. A frame whose line is sampled through a
  // two-flop synchroniser is seen 2 clocks late; the strobe follows the last
  // stop sample by one clock, i.e. it is visible after edge k+2+bits*div.
  function automatic ev_t predict(input int inst, input int nbits, input int par_mode,
                                  input logic [8:0] data, input logic parbit, input int nstop,
                                  input logic [1:0] stops, input int div, input int k);
    ev_t e;
    int  ones, npar;
    logic [8:0] d;
    d       = data & 9'((1 << nbits) - 1);
    npar    = (par_mode != 0) ? 1 : 0;
    e.valid = 1'b1;
    e.inst  = 2'(inst);
    e.brk   = (d == 9'd0) && ((npar == 0) || (parbit == 1'b0)) && (stops[0] == 1'b0);
    if (e.brk) begin
      e.data = '0;
      e.perr = 1'b0;
      e.ferr = 1'b1;
      e.cyc  = 32'(k + 2 + (2 + nbits + npar) * div);
    end else begin
      ones   = $countones(d) + ((npar != 0 && parbit) ? 1 : 0);
      e.data = d;
      e.perr = (par_mode == 1) ? (ones % 2 == 0) : (par_mode == 2) ? (ones % 2 == 1) : 1'b0;
      e.ferr = (stops[0] == 1'b0) || ((nstop == 2) && (stops[1] == 1'b0));
      e.cyc  = 32'(k + 2 + (1 + nbits + npar + nstop) * div);
    end
    return e;
  endfunction

  task automatic send_frame(input int inst, input int nbits, input logic [8:0] data,
                            input bit has_par, input logic parbit, input int nstop,
                            input logic [1:0] stops, input int div, output int k);
    @(posedge clk);
    #1;
    k       = cyc;
    divisor = 16'(div);
    r_line[inst] = 1'b0;
    repeat (div) @(posedge clk);
    for (int b = 0; b < nbits; b++) begin
      #1 r_line[inst] = data[b];
      repeat (div) @(posedge clk);
    end
    if (has_par) begin
      #1 r_line[inst] = parbit;
      repeat (div) @(posedge clk);
    end
    for (int s = 0; s < nstop; s++) begin
      #1 r_line[inst] = stops[s];
      repeat (div) @(posedge clk);
    end
    #1 r_line[inst] = 1'b1;
  endtask

  task automatic test_reset();
    tests++;
    if ({dout0, dout1, dout2, valid, perr, ferr, brk, ito, busy} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got %h, expected 0",
               {dout0, dout1, dout2, valid, perr, ferr, brk, ito, busy});
    end
  endtask

  task automatic test_8n1();
    int k, div;
    logic [8:0] d;
    logic [1:0] st;
    ev_t e_exp, e_got;
    for (int n = 0; n < 6; n++) begin
      div = (n == 0) ? 48 : int'($urandom_range(4, 40));
      d   = (n == 0) ? 9'h055 : 9'($urandom_range(0, 255));
      st  = ($urandom_range(0, 3) == 0) ? 2'b10 : 2'b11;
      if (n == 5) d = 9'h000;
      send_frame(0, 8, d, 1'b0, 1'b0, 1, st, div, k);
      e_exp = predict(0, 8, 0, d, 1'b0, 1, st, div, k);
      repeat (div + 8) @(posedge clk);
      tests++;
      if (evq.size() != 1) begin
        fails++;
        $display("FAIL 8n1_count[%0d]: got %0d strobes, expected 1", n, evq.size());
        evq.delete();
      end else begin
        e_got = evq.pop_front();
        tests++;
        if (e_got !== e_exp) begin
          fails++;
          $display("FAIL 8n1_frame[%0d]: got %s, expected %s", n, fmt(e_got), fmt(e_exp));
        end
      end
    end
  endtask

  task automatic test_7e1_parity();
    int k;
    logic [8:0] d;
    logic pb;
    ev_t e_exp, e_got;
    for (int n = 0; n < 5; n++) begin
      d  = (n < 2) ? 9'h041 : 9'($urandom_range(1, 127));
      pb = (n == 0) ? 1'b1 : (n == 1) ? 1'b0 : 1'($urandom_range(0, 1));
      send_frame(1, 7, d, 1'b1, pb, 1, 2'b11, 16, k);
      e_exp = predict(1, 7, 2, d, pb, 1, 2'b11, 16, k);
      repeat (24) @(posedge clk);
      tests++;
      if (evq.size() != 1) begin
        fails++;
        $display("FAIL 7e1_count[%0d]: got %0d strobes, expected 1", n, evq.size());
        evq.delete();
      end else begin
        e_got = evq.pop_front();
        tests++;
        if (e_got !== e_exp) begin
          fails++;
          $display("FAIL 7e1_frame[%0d]: got %s, expected %s", n, fmt(e_got), fmt(e_exp));
        end
      end
    end
  endtask

  task automatic test_glitch();
    idle_limit = 16'd20;
    divisor    = 16'd48;
    repeat (40) @(posedge clk);
    #1;
    tests++;
    if (ito[0] !== 1'b1) begin
      fails++;
      $display("FAIL glitch_pre_timeout: got %b, expected 1", ito[0]);
    end
    r_line[0] = 1'b0;
    repeat (10) @(posedge clk);
    #1 r_line[0] = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    tests++;
    if ({busy[0], ito[0]} !== 2'b11) begin
      fails++;
      $display("FAIL glitch_in_start: got busy/timeout %b, expected 11", {busy[0], ito[0]});
    end
    repeat (50) @(posedge clk);
    #1;
    tests++;
    if ({busy[0], ito[0], 32'(evq.size())} !== {2'b01, 32'd0}) begin
      fails++;
      $display("FAIL glitch_after: got busy=%b timeout=%b strobes=%0d, expected busy=0 timeout=1 strobes=0",
               busy[0], ito[0], evq.size());
      evq.delete();
    end
  endtask

  task automatic test_break();
    int k;
    logic [8:0] d;
    ev_t e_exp, e_got;
    divisor = 16'd16;
    @(posedge clk);
    #1;
    k = cyc;
    r_line[0] = 1'b0;
    repeat (11 * 16) @(posedge clk);
    #1;
    tests++;
    if (busy[0] !== 1'b1) begin
      fails++;
      $display("FAIL break_wait_busy: got %b, expected 1", busy[0]);
    end
    repeat (16) @(posedge clk);
    #1 r_line[0] = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    e_exp = predict(0, 8, 0, 9'h000, 1'b0, 1, 2'b00, 16, k);
    tests++;
    if (evq.size() != 1 || busy[0] !== 1'b0) begin
      fails++;
      $display("FAIL break_count: got %0d strobes busy=%b, expected 1 strobe busy=0", evq.size(), busy[0]);
      evq.delete();
    end else begin
      e_got = evq.pop_front();
      tests++;
      if (e_got !== e_exp) begin
        fails++;
        $display("FAIL break_frame: got %s, expected %s", fmt(e_got), fmt(e_exp));
      end
    end
    d = 9'h0A3;
    send_frame(0, 8, d, 1'b0, 1'b0, 1, 2'b11, 16, k);
    e_exp = predict(0, 8, 0, d, 1'b0, 1, 2'b11, 16, k);
    repeat (24) @(posedge clk);
    tests++;
    if (evq.size() != 1) begin
      fails++;
      $display("FAIL after_break_count: got %0d strobes, expected 1", evq.size());
      evq.delete();
    end else begin
      e_got = evq.pop_front();
      tests++;
      if (e_got !== e_exp) begin
        fails++;
        $display("FAIL after_break_frame: got %s, expected %s", fmt(e_got), fmt(e_exp));
      end
    end
  endtask

  task automatic test_idle_timeout();
    int k;
    logic [8:0] d;
    ev_t e_exp, e_got;
    idle_limit = 16'd100;
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (90) @(posedge clk);
    #1;
    tests++;
    if (ito[0] !== 1'b0) begin
      fails++;
      $display("FAIL idle_early: got %b, expected 0", ito[0]);
    end
    repeat (20) @(posedge clk);
    #1;
    tests++;
    if (ito[0] !== 1'b1) begin
      fails++;
      $display("FAIL idle_reached: got %b, expected 1", ito[0]);
    end
    d = 9'($urandom_range(0, 255)) | 9'h001;
    fork
      send_frame(0, 8, d, 1'b0, 1'b0, 1, 2'b11, 32, k);
      begin
        @(posedge clk);
        repeat (16) @(posedge clk);
        #2;
        tests++;
        if (ito[0] !== 1'b1) begin
          fails++;
          $display("FAIL idle_mid_start: got %b, expected 1", ito[0]);
        end
        repeat (20) @(posedge clk);
        #2;
        tests++;
        if (ito[0] !== 1'b0) begin
          fails++;
          $display("FAIL idle_cleared: got %b, expected 0", ito[0]);
        end
      end
    join
    e_exp = predict(0, 8, 0, d, 1'b0, 1, 2'b11, 32, k);
    repeat (40) @(posedge clk);
    tests++;
    if (evq.size() != 1) begin
      fails++;
      $display("FAIL idle_frame_count: got %0d strobes, expected 1", evq.size());
      evq.delete();
    end else begin
      e_got = evq.pop_front();
      tests++;
      if (e_got !== e_exp) begin
        fails++;
        $display("FAIL idle_frame: got %s, expected %s", fmt(e_got), fmt(e_exp));
      end
    end
  endtask

  task automatic test_8n2_and_reset();
    int k;
    logic [8:0] d;
    logic [1:0] st;
    ev_t e_exp, e_got;
    idle_limit = 16'd1000;
    for (int n = 0; n < 4; n++) begin
      d  = (n == 3) ? 9'h03C : (n == 0) ? 9'h05A : 9'($urandom_range(1, 255));
      st = (n == 0) ? 2'b01 : (n == 3) ? 2'b11 : 2'($urandom_range(0, 3)) | 2'b01;
      if (n == 3) begin
        // Abandon a frame in the middle of its data bits with an async reset.
        @(posedge clk);
        #1 r_line[2] = 1'b0;
        divisor = 16'd20;
        repeat (20) @(posedge clk);
        #1 r_line[2] = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        tests++;
        if (busy[2] !== 1'b1) begin
          fails++;
          $display("FAIL pre_reset_busy: got %b, expected 1", busy[2]);
        end
        reset = 1'b1;
        #2;
        tests++;
        if ({dout2, valid[2], perr[2], ferr[2], brk[2], ito[2], busy[2]} !== '0) begin
          fails++;
          $display("FAIL mid_frame_reset: got %h, expected 0",
                   {dout2, valid[2], perr[2], ferr[2], brk[2], ito[2], busy[2]});
        end
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        repeat (240) @(posedge clk);
        tests++;
        if (evq.size() != 0) begin
          fails++;
          $display("FAIL reset_no_strobe: got %0d strobes, expected 0", evq.size());
          evq.delete();
        end
      end
      send_frame(2, 8, d, 1'b0, 1'b0, 2, st, 20, k);
      e_exp = predict(2, 8, 0, d, 1'b0, 2, st, 20, k);
      repeat (30) @(posedge clk);
      tests++;
      if (evq.size() != 1) begin
        fails++;
        $display("FAIL 8n2_count[%0d]: got %0d strobes, expected 1", n, evq.size());
        evq.delete();
      end else begin
        e_got = evq.pop_front();
        tests++;
        if (e_got !== e_exp) begin
          fails++;
          $display("FAIL 8n2_frame[%0d]: got %s, expected %s", n, fmt(e_got), fmt(e_exp));
        end
      end
    end
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset      = 1'b1;
    r_line     = 3'b111;
    divisor    = 16'd48;
    idle_limit = 16'd1000;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    reset = 1'b0;
    repeat (5) @(posedge clk);
    test_8n1();
    test_7e1_parity();
    test_glitch();
    test_break();
    test_idle_timeout();
    test_8n2_and_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
